// File: rtl/can_tx_framer.sv
// CAN 2.0A/2.0B transmit framer.
// Latches a message on start&ready and serialises SOF..IFS on tx, one bit per
// bit_tick. The CRC-15 is computed serially, and stuff bits are inserted from
// SOF through the last CRC bit. The framer watches rx for arbitration loss and
// for a missing ACK.
// Ports:
//   clk, rst       clock, async active-high reset
//   bit_tick       one-clk strobe per CAN bit time
//   start/ready    message handshake
//   id/ide/rtr/dlc/data  message fields, latched on accept
//   rx             sampled bus level (0 = dominant)
//   tx             serial bus output (1 = recessive)
//   busy           frame in progress
//   done           one-clk pulse at end of IFS
//   ack_err        no dominant ACK seen, held until next accept
//   arb_lost       one-clk pulse when arbitration is lost
module can_tx_framer #(
  parameter int unsigned MAX_BYTES = 8,
  parameter logic [14:0] CRC_POLY  = 15'h4599
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bit_tick,
  input  logic                   start,
  output logic                   ready,
  input  logic [28:0]            id,
  input  logic                   ide,
  input  logic                   rtr,
  input  logic [3:0]             dlc,
  input  logic [MAX_BYTES*8-1:0] data,
  input  logic                   rx,
  output logic                   tx,
  output logic                   busy,
  output logic                   done,
  output logic                   ack_err,
  output logic                   arb_lost
);

  localparam int unsigned DATA_W  = MAX_BYTES * 8;
  // Longest pre-CRC header (extended) is 39 bits.
  localparam int unsigned FRAME_W = 39 + DATA_W;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_SOF      = 4'd1;
  localparam logic [3:0] ST_ARB      = 4'd2;
  localparam logic [3:0] ST_CTRL     = 4'd3;
  localparam logic [3:0] ST_DATA     = 4'd4;
  localparam logic [3:0] ST_CRC      = 4'd5;
  localparam logic [3:0] ST_CRC_DEL  = 4'd6;
  localparam logic [3:0] ST_ACK_SLOT = 4'd7;
  localparam logic [3:0] ST_ACK_DEL  = 4'd8;
  localparam logic [3:0] ST_EOF      = 4'd9;
  localparam logic [3:0] ST_IFS      = 4'd10;

  // state_q is the field of the bit currently on tx.
  // rem_q counts the unstuffed bits of that field still to follow.
  logic [3:0]         state_q, state_d;
  logic [6:0]         rem_q, rem_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic               ide_q, ide_d;
  logic [3:0]         nbytes_q, nbytes_d;
  logic [14:0]        crc_q, crc_d;
  logic               run_bit_q, run_bit_d;
  logic [2:0]         run_cnt_q, run_cnt_d;
  logic               tx_q, tx_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ack_err_q, ack_err_d;
  logic               arb_lost_q, arb_lost_d;

  logic [DATA_W-1:0]  payload;
  logic [FRAME_W-1:0] frame_load;
  logic [3:0]         nbytes_load;
  logic [3:0]         fld_state;
  logic [6:0]         fld_rem;
  logic               bit_val;

  // Unstuffed SOF..data bit sequence, left aligned, first bit at the MSB.
  always_comb begin : build_frame
    payload = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      payload[DATA_W-1-8*i -: 8] = data[8*i +: 8];
    end
    if (ide) begin
      frame_load = {1'b0, id[28:18], 1'b1, 1'b1, id[17:0], rtr, 2'b00, dlc, payload};
    end else begin
      frame_load = {1'b0, id[10:0], rtr, 2'b00, dlc, payload, 20'b0};
    end
    if (rtr) begin
      nbytes_load = 4'd0;
    end else if (dlc > 4'(MAX_BYTES)) begin
      nbytes_load = 4'(MAX_BYTES);
    end else begin
      nbytes_load = dlc;
    end
  end

  // Next-state and bit-level sequencing.
  always_comb begin : next_state
    state_d    = state_q;
    rem_d      = rem_q;
    shreg_d    = shreg_q;
    ide_d      = ide_q;
    nbytes_d   = nbytes_q;
    crc_d      = crc_q;
    run_bit_d  = run_bit_q;
    run_cnt_d  = run_cnt_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ack_err_d  = ack_err_q;
    arb_lost_d = 1'b0;
    fld_state  = state_q;
    fld_rem    = rem_q;
    bit_val    = 1'b1;

    if (start && ready_q) begin
      shreg_d   = frame_load;
      ide_d     = ide;
      nbytes_d  = nbytes_load;
      crc_d     = '0;
      run_bit_d = 1'b1;
      run_cnt_d = '0;
      rem_d     = '0;
      state_d   = ST_IDLE;
      ready_d   = 1'b0;
      busy_d    = 1'b1;
      ack_err_d = 1'b0;
    end else if (bit_tick && busy_q) begin
      if (state_q == ST_ARB && tx_q && !rx) begin
        // Another node drove dominant over our recessive arbitration bit.
        tx_d       = 1'b1;
        arb_lost_d = 1'b1;
        state_d    = ST_IDLE;
        busy_d     = 1'b0;
        ready_d    = 1'b1;
      end else if (state_q == ST_IFS && rem_q == '0) begin
        tx_d    = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end else if ((state_q inside {ST_SOF, ST_ARB, ST_CTRL, ST_DATA, ST_CRC})
                   && run_cnt_q == 3'd5) begin
        // Stuff bit: the field does not advance, so it inherits the current field.
        tx_d      = ~run_bit_q;
        run_bit_d = ~run_bit_q;
        run_cnt_d = 3'd1;
      end else begin
        if (state_q == ST_ACK_SLOT) begin
          ack_err_d = rx;
        end
        if (rem_q != '0) begin
          fld_rem = rem_q - 7'd1;
        end else begin
          unique case (state_q)
            ST_IDLE:     begin fld_state = ST_SOF;      fld_rem = 7'd0;  end
            ST_SOF:      begin fld_state = ST_ARB;      fld_rem = ide_q ? 7'd31 : 7'd11; end
            ST_ARB:      begin fld_state = ST_CTRL;     fld_rem = 7'd5;  end
            ST_CTRL: begin
              if (nbytes_q != 4'd0) begin
                fld_state = ST_DATA;
                fld_rem   = {nbytes_q, 3'b000} - 7'd1;
              end else begin
                fld_state = ST_CRC;
                fld_rem   = 7'd14;
              end
            end
            ST_DATA:     begin fld_state = ST_CRC;      fld_rem = 7'd14; end
            ST_CRC:      begin fld_state = ST_CRC_DEL;  fld_rem = 7'd0;  end
            ST_CRC_DEL:  begin fld_state = ST_ACK_SLOT; fld_rem = 7'd0;  end
            ST_ACK_SLOT: begin fld_state = ST_ACK_DEL;  fld_rem = 7'd0;  end
            ST_ACK_DEL:  begin fld_state = ST_EOF;      fld_rem = 7'd6;  end
            ST_EOF:      begin fld_state = ST_IFS;      fld_rem = 7'd2;  end
            default:     begin fld_state = ST_IDLE;     fld_rem = 7'd0;  end
          endcase
        end
        state_d = fld_state;
        rem_d   = fld_rem;

        unique case (fld_state)
          ST_SOF, ST_ARB, ST_CTRL, ST_DATA: begin
            bit_val = shreg_q[FRAME_W-1];
            shreg_d = shreg_q << 1;
            crc_d   = {crc_q[13:0], 1'b0} ^ ((bit_val ^ crc_q[14]) ? CRC_POLY : 15'h0);
          end
          ST_CRC: begin
            bit_val = crc_q[14];
            crc_d   = {crc_q[13:0], 1'b0};
          end
          default: bit_val = 1'b1;
        endcase
        tx_d = bit_val;

        if (fld_state inside {ST_SOF, ST_ARB, ST_CTRL, ST_DATA, ST_CRC}) begin
          if (run_cnt_q != 3'd0 && bit_val == run_bit_q) begin
            run_cnt_d = run_cnt_q + 3'd1;
          end else begin
            run_bit_d = bit_val;
            run_cnt_d = 3'd1;
          end
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      shreg_q    <= '0;
      ide_q      <= 1'b0;
      nbytes_q   <= '0;
      crc_q      <= '0;
      run_bit_q  <= 1'b1;
      run_cnt_q  <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      arb_lost_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      shreg_q    <= shreg_d;
      ide_q      <= ide_d;
      nbytes_q   <= nbytes_d;
      crc_q      <= crc_d;
      run_bit_q  <= run_bit_d;
      run_cnt_q  <= run_cnt_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      arb_lost_q <= arb_lost_d;
    end
  end

  assign tx       = tx_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ack_err  = ack_err_q;
  assign arb_lost = arb_lost_q;

endmodule
